// File: rtl/sbit_tx_pkg.sv
// sbit_tx_pkg: shared types and constants for the S-bit trigger-path transmitter.
//   tx_state_t       : IDLE / TRAIN / DATA, encoded as exported on the `state` port
//   FRAME_BITS       : bits per frame (one S-bit word)
//   PAIRS_PER_FRAME  : DDR bit pairs (clock cycles) per frame
//   PRBS7_SEED/TAPS  : PRBS-7 (x^7 + x^6 + 1) generator constants
//   prbs7_step       : one-bit advance of the PRBS-7 register
package sbit_tx_pkg;

  localparam int unsigned FRAME_BITS      = 8;
  localparam int unsigned PAIRS_PER_FRAME = 4;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b1100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } tx_state_t;

  // Shift left, feeding back the XOR of the tapped bits; the new bit lands in [0].
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/sbit_tx_serializer_prbs7.sv
// prbs7_byte_gen: PRBS-7 generator producing FRAME_BITS new sequence bits per enable.
//   clock     : fast clock
//   reset     : synchronous, active-high; reloads the seed
//   en        : advance the generator by one byte at the next edge
//   prbs_byte : the next byte of the sequence, first-generated bit in the MSB
module prbs7_byte_gen
  import sbit_tx_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  output logic [FRAME_BITS-1:0] prbs_byte
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  always_comb begin
    lfsr_d    = lfsr_q;
    prbs_byte = '0;
    for (int unsigned i = 0; i < FRAME_BITS; i++) begin
      lfsr_d = prbs7_step(lfsr_d);
      prbs_byte[FRAME_BITS-1-i] = lfsr_d[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= PRBS7_SEED;
    end else if (en) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/sbit_tx_serializer.sv
// sbit_tx_serializer: frames 8-bit S-bit words into a DDR bit-pair stream, one frame
// per four `clock` cycles, with a start-of-frame marker, for an external ODDR.
//   clock          : fast clock (4x frame rate)
//   reset          : synchronous, active-high
//   tx_en          : enable transmission
//   train_req      : level, requests a training burst
//   data_in        : frame payload, MSB first
//   data_valid     : data_in is valid
//   data_ready     : word accepted this cycle (with data_valid)
//   d0, d1         : earlier / later bit of the current pair
//   sof_d0, sof_d1 : SOF marker aligned to d0 / d1
//   state          : 0=IDLE, 1=TRAIN, 2=DATA
//   underflow_cnt  : saturating count of DATA frames sent without a valid word
// Optional build macro SBIT_TX_PRBS_EN adds input prbs_sel and a PRBS-7 payload source.
module sbit_tx_serializer
  import sbit_tx_pkg::*;
#(
  parameter int unsigned POSNEG       = 0,
  parameter logic [7:0]  TRAIN_WORD   = 8'hA5,
  parameter int unsigned TRAIN_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       train_req,
  input  logic [7:0] data_in,
  input  logic       data_valid,
`ifdef SBIT_TX_PRBS_EN
  input  logic       prbs_sel,
`endif
  output logic       data_ready,
  output logic       d0,
  output logic       d1,
  output logic       sof_d0,
  output logic       sof_d1,
  output logic [1:0] state,
  output logic [7:0] underflow_cnt
);

  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_FRAMES - 1);
  localparam logic [1:0] PH_LAST    = 2'(PAIRS_PER_FRAME - 1);

  tx_state_t             st_q, st_d;
  logic [1:0]            ph_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic [FRAME_BITS-1:0] frame_d;
  logic [FRAME_BITS-1:0] prbs_byte;
  logic                  sof_q;
  logic                  frame_sof_d;
  logic                  dly_q;
  logic                  boundary;
  logic                  underrun;
  logic                  prbs_on;
  logic [7:0]            train_cnt_q;
  logic [7:0]            uf_q;

  assign boundary      = (ph_q == PH_LAST);
  assign state         = st_q;
  assign underflow_cnt = uf_q;

`ifdef SBIT_TX_PRBS_EN
  assign prbs_on = prbs_sel;

  prbs7_byte_gen u_prbs (
    .clock     (clock),
    .reset     (reset),
    .en        (boundary && (st_d == ST_DATA) && prbs_sel),
    .prbs_byte (prbs_byte)
  );
`else
  assign prbs_on   = 1'b0;
  assign prbs_byte = '0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Next state: only moves at the frame boundary; !tx_en wins over everything.
  always_comb begin
    st_d = st_q;
    if (boundary) begin
      if (!tx_en) begin
        st_d = ST_IDLE;
      end else begin
        case (st_q)
          ST_IDLE:  st_d = ST_TRAIN;
          ST_TRAIN: if (train_cnt_q == TRAIN_LAST) st_d = ST_DATA;
          ST_DATA:  if (train_req) st_d = ST_TRAIN;
          default:  st_d = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs: next-frame content (selected by the state being entered) and pin mapping.
  always_comb begin
    frame_d     = '0;
    frame_sof_d = 1'b0;
    underrun    = 1'b0;
    case (st_d)
      ST_TRAIN: begin
        frame_d     = TRAIN_WORD;
        frame_sof_d = 1'b1;
      end
      ST_DATA: begin
        frame_sof_d = 1'b1;
        if (prbs_on) begin
          frame_d = prbs_byte;
        end else if (data_valid) begin
          frame_d = data_in;
        end else begin
          underrun = boundary;
        end
      end
      default: ;
    endcase

    data_ready = boundary && (st_d == ST_DATA) && !prbs_on;

    // POSNEG: the stream slips one bit later, so the pair straddles two sr positions.
    if (POSNEG != 0) begin
      d0     = dly_q;
      d1     = sr_q[FRAME_BITS-1];
      sof_d0 = 1'b0;
      sof_d1 = sof_q && (ph_q == 2'd0);
    end else begin
      d0     = sr_q[FRAME_BITS-1];
      d1     = sr_q[FRAME_BITS-2];
      sof_d0 = sof_q && (ph_q == 2'd0);
      sof_d1 = 1'b0;
    end
  end

  // Datapath: phase, shift register, SOF flag, training and underflow counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      ph_q        <= '0;
      sr_q        <= '0;
      sof_q       <= 1'b0;
      dly_q       <= 1'b0;
      train_cnt_q <= '0;
      uf_q        <= '0;
    end else begin
      ph_q  <= ph_q + 2'd1;
      dly_q <= sr_q[FRAME_BITS-2];
      if (boundary) begin
        sr_q  <= frame_d;
        sof_q <= frame_sof_d;
        // Held at zero outside TRAIN, so entering TRAIN always starts a fresh burst.
        if (st_q == ST_TRAIN) begin
          train_cnt_q <= train_cnt_q + 8'd1;
        end else begin
          train_cnt_q <= '0;
        end
        if (underrun && (uf_q != '1)) begin
          uf_q <= uf_q + 8'd1;
        end
      end else begin
        sr_q <= {sr_q[FRAME_BITS-3:0], 2'b00};
      end
    end
  end

endmodule
